// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift arbiter and its shifter datapath.
package shift_arb_pkg;

  localparam int SHIFT_W     = 32;
  localparam int SHAMT_W     = 5;
  localparam int GRANT_CNT_W = 16;

  // Output-register occupancy.
  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_e;

  // One shift command as presented by a requester.
  typedef struct packed {
    logic [SHIFT_W-1:0] operand;
    logic [SHAMT_W-1:0] amount;
    logic               left;
    logic               arith;
  } shift_cmd_t;

endpackage

// File: rtl/shifter_unit.sv
// Combinational 32-bit barrel shifter: left, logical right, arithmetic right.
module shifter_unit
  import shift_arb_pkg::*;
(
  input  shift_cmd_t         cmd_i,
  output logic [SHIFT_W-1:0] result_o
);

  // Select shift direction; arith only matters for right shifts.
  always_comb begin
    if (cmd_i.left) begin
      result_o = cmd_i.operand << cmd_i.amount;
    end else if (cmd_i.arith) begin
      result_o = $signed(cmd_i.operand) >>> cmd_i.amount;
    end else begin
      result_o = cmd_i.operand >> cmd_i.amount;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter_unit between NUM_REQ requesters.
// Accepts one command per cycle into a single output register and returns
// the result tagged with the requester index.
// Optional per-requester saturating grant counters: define SHIFT_ARB_STATS_EN.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*SHIFT_W-1:0] req_operand_i,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_amount_i,
  input  logic [NUM_REQ-1:0]         req_left_i,
  input  logic [NUM_REQ-1:0]         req_arith_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [SHIFT_W-1:0]         rsp_data_o,
  output logic [ID_W-1:0]            rsp_id_o
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*GRANT_CNT_W-1:0] grant_cnt_o
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SHIFT_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

  logic               slot_free;
  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  shift_cmd_t         grant_cmd;
  logic [SHIFT_W-1:0] shift_res;

  assign rsp_valid_o = (state_q == FULL);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;

  // The register can take a new command when empty or being drained now.
  assign slot_free = (state_q == IDLE) || (rsp_valid_o && rsp_ready_i);

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  // Reset gates the grant so no handshake completes while rst_i is high.
  always_comb begin : rr_pick
    int cand;
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!rst_i && slot_free && !grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
  end

  // One-hot ready for the granted requester only.
  always_comb begin
    req_ready_o = '0;
    if (grant_vld) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Grant mux feeding the shared shifter.
  always_comb begin
    grant_cmd.operand = req_operand_i[grant_idx*SHIFT_W +: SHIFT_W];
    grant_cmd.amount  = req_amount_i[grant_idx*SHAMT_W +: SHAMT_W];
    grant_cmd.left    = req_left_i[grant_idx];
    grant_cmd.arith   = req_arith_i[grant_idx];
  end

  shifter_unit u_shifter (
    .cmd_i    (grant_cmd),
    .result_o (shift_res)
  );

  // Next-state: load on grant (possibly while draining), empty on drain.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = FULL;
      FULL:    if (rsp_ready_i && !grant_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (grant_vld) begin
      rsp_data_d = shift_res;
      rsp_id_d   = ID_W'(grant_idx);
      rr_ptr_d   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // State, pointer and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the response data/id are reset too, not just the valid state,
    // so a held response is discarded and the outputs read 0 after reset.
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  logic [NUM_REQ-1:0]     xfer;
  logic [GRANT_CNT_W-1:0] grant_cnt_q [NUM_REQ];

  assign xfer = req_valid_i & req_ready_o;

  // Saturating per-requester transfer counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) grant_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (xfer[k] && (grant_cnt_q[k] != '1)) begin
          grant_cnt_q[k] <= grant_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt_out
    assign grant_cnt_o[k*GRANT_CNT_W +: GRANT_CNT_W] = grant_cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter (NUM_REQ = 2) with a transaction-level
// reference model: one pending-response slot and a round-robin pointer.
module tb_shift_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_operand;
  logic [N*5-1:0]  req_amount;
  logic [N-1:0]    req_left;
  logic [N-1:0]    req_arith;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic            rsp_id;
`ifdef SHIFT_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  shift_arbiter #(.NUM_REQ(N)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_operand_i (req_operand),
    .req_amount_i  (req_amount),
    .req_left_i    (req_left),
    .req_arith_i   (req_arith),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .rsp_id_o      (rsp_id)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant_cnt_o   (grant_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_valid;
  logic [31:0] m_data;
  logic        m_id;
  int          m_ptr;

  // Values captured by tick(): observed (DUT) and expected (model).
  logic [N-1:0] obs_ready, exp_ready;
  logic         obs_valid, exp_valid;
  logic [31:0]  obs_data, exp_data;
  logic         obs_id, exp_id;
  int           last_grant = -1;

  function automatic logic [31:0] ref_shift(input logic [31:0] op, input int amt,
                                            input bit left, input bit arith);
    logic [31:0] r;
    if (left) begin
      r = op << amt;
    end else begin
      r = op >> amt;
      if (arith && op[31]) r = r | ~(32'hFFFF_FFFF >> amt);
    end
    return r;
  endfunction

  function automatic int ref_pick();
    if (rst) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 1'b0;
    m_ptr   = 0;
  endtask

  // Sample DUT and model at the falling edge, then advance the model at the
  // rising edge; returns at rising edge + 1 ready for new stimulus.
  task automatic tick();
    int g;
    @(negedge clk);
    g = ref_pick();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_valid = m_valid;
    exp_data  = m_data;
    exp_id    = m_id;
    obs_ready = req_ready;
    obs_valid = rsp_valid;
    obs_data  = rsp_data;
    obs_id    = rsp_id;
    last_grant = g;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = ref_shift(req_operand[g*32 +: 32], int'(req_amount[g*5 +: 5]),
                          req_left[g], req_arith[g]);
      m_id    = 1'(g);
      m_ptr   = (g + 1) % N;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_operand = '0; req_amount = '0; req_left = '0; req_arith = '0;
    rsp_ready = 1'b1;
    model_reset();
    tick();
    req_valid = 2'b11;
    tick();
    checks++;
    if (obs_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", obs_ready);
    end
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", obs_valid);
    end
    checks++;
    if (obs_data !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 00000000", obs_data);
    end
    checks++;
    if (obs_id !== 1'b0) begin
      errors++; $display("FAIL reset_id: got %b expected 0", obs_id);
    end
    req_valid = '0;
  endtask

  task automatic test_directed_shift();
    rst = 1'b0;
    req_operand[31:0] = 32'h0000_0001; req_amount[4:0] = 5'd4;
    req_left[0] = 1'b1; req_arith[0] = 1'b0;
    req_valid = 2'b01;
    tick();
    checks++;
    if (obs_ready !== 2'b01) begin
      errors++; $display("FAIL first_grant: got %b expected 01", obs_ready);
    end
    req_valid = 2'b00;
    tick();
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 32'h10 || obs_id !== 1'b0) begin
      errors++;
      $display("FAIL first_rsp: got v=%b d=%h id=%b expected v=1 d=00000010 id=0",
               obs_valid, obs_data, obs_id);
    end
    tick();
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL drain_idle: got %b expected 0", obs_valid);
    end
  endtask

  task automatic test_arith_right();
    logic [31:0] want [2];
    want[0] = 32'hFFFF_FFFF;
    want[1] = 32'h0000_0001;
    for (int pass = 0; pass < 2; pass++) begin
      req_operand[63:32] = 32'h8000_0000; req_amount[9:5] = 5'd31;
      req_left[1] = 1'b0; req_arith[1] = (pass == 0);
      req_valid = 2'b10;
      tick();
      checks++;
      if (obs_ready !== 2'b10) begin
        errors++; $display("FAIL right_grant%0d: got %b expected 10", pass, obs_ready);
      end
      req_valid = 2'b00;
      tick();
      checks++;
      if (obs_valid !== 1'b1 || obs_data !== want[pass] || obs_id !== 1'b1) begin
        errors++;
        $display("FAIL right_rsp%0d: got v=%b d=%h id=%b expected v=1 d=%h id=1",
                 pass, obs_valid, obs_data, obs_id, want[pass]);
      end
    end
    tick();
  endtask

  task automatic test_fairness();
    logic prev_g;
    for (int k = 0; k < N; k++) begin
      req_operand[k*32 +: 32] = $urandom();
      req_amount[k*5 +: 5]    = 5'($urandom_range(0, 31));
      req_left[k]  = 1'($urandom_range(0, 1));
      req_arith[k] = 1'($urandom_range(0, 1));
    end
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    prev_g = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] want;
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      checks++;
      if (obs_ready !== want) begin
        errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, obs_ready, want);
      end
      if (i > 0) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_id !== prev_g || obs_data !== exp_data) begin
          errors++;
          $display("FAIL rr_rsp%0d: got v=%b id=%b d=%h expected v=1 id=%b d=%h",
                   i, obs_valid, obs_id, obs_data, prev_g, exp_data);
        end
      end
      prev_g = 1'(i % 2);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_data;
    logic        held_id;
    held_data = m_data;
    held_id   = m_id;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_ready !== 2'b00 || obs_valid !== 1'b1 || obs_data !== held_data ||
          obs_id !== held_id) begin
        errors++;
        $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%h id=%b expected rdy=00 v=1 d=%h id=%b",
                 i, obs_ready, obs_valid, obs_data, obs_id, held_data, held_id);
      end
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (obs_valid !== 1'b1 || obs_ready !== exp_ready || exp_ready == 2'b00) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b expected v=1 rdy=%b (nonzero)",
               obs_valid, obs_ready, exp_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!(req_valid[k] && last_grant != k)) begin
          int r;
          r = $urandom_range(0, 7);
          req_valid[k] = 1'($urandom_range(0, 1));
          req_operand[k*32 +: 32] = $urandom();
          req_amount[k*5 +: 5] = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 :
                                 5'($urandom_range(0, 31));
          req_left[k]  = 1'($urandom_range(0, 1));
          req_arith[k] = 1'($urandom_range(0, 1));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        errors++;
        $display("FAIL rand_ctl%0d: got rdy=%b v=%b expected rdy=%b v=%b",
                 c, obs_ready, obs_valid, exp_ready, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (obs_data !== exp_data || obs_id !== exp_id) begin
          errors++;
          $display("FAIL rand_rsp%0d: got d=%h id=%b expected d=%h id=%b",
                   c, obs_data, obs_id, exp_data, exp_id);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    req_operand[31:0] = 32'h1234_5678; req_amount[4:0] = 5'd8;
    req_left[0] = 1'b1; req_arith[0] = 1'b0;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full: got %b expected 1", rsp_valid);
    end
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got v=%b rdy=%b expected v=0 rdy=00", rsp_valid, req_ready);
    end
    model_reset();
    tick();
    rst = 1'b0;
    req_operand[63:32] = 32'h0000_00F0; req_amount[9:5] = 5'd4;
    req_left[1] = 1'b0; req_arith[1] = 1'b0;
    tick();
    checks++;
    if (obs_ready !== 2'b01 || obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_grant: got rdy=%b v=%b expected rdy=01 v=0",
               obs_ready, obs_valid);
    end
    req_valid = 2'b00;
    tick();
    checks++;
    if (obs_valid !== 1'b1 || obs_id !== 1'b0 || obs_data !== 32'h3456_7800) begin
      errors++;
      $display("FAIL post_reset_rsp: got v=%b id=%b d=%h expected v=1 id=0 d=34567800",
               obs_valid, obs_id, obs_data);
    end
    tick();
  endtask

`ifdef SHIFT_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b01;
    repeat (70000) @(posedge clk);
    #1 req_valid = 2'b10;
    repeat (5) @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    #1;
    checks++;
    if (grant_cnt[15:0] !== 16'hFFFF) begin
      errors++; $display("FAIL stats_sat: got %h expected ffff", grant_cnt[15:0]);
    end
    checks++;
    if (grant_cnt[31:16] !== 16'd5) begin
      errors++; $display("FAIL stats_exact: got %0d expected 5", grant_cnt[31:16]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed_shift();
    test_arith_right();
    test_fairness();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef SHIFT_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
